vm_change_dispenser: RTL and testbench

Change-payout controller for the vending machine. It accepts a change request in ₹5 units from the vending FSM and sequences the ₹10 and ₹5 coin-tube eject solenoids, one coin at a time, with timed pulses. It tracks tube inventory from customer coin deposits and reports completion, including shortage when inventory cannot cover the request. It sits between the vending FSM's change/return outputs and the coin-mechanism drivers.

---
 rtl/vm_change_dispenser.sv | 227 ++++++++++++++++++++++
 tb/tb_vm_change_dispenser.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_change_dispenser.sv
// ---------------------------------------------------------------------------
// vm_change_dispenser
//
// Change-payout controller. Accepts a change request (in Rs.5 units) and
// pays it out one coin at a time from the Rs.10 and Rs.5 tubes. Each coin is
// driven as a timed solenoid pulse followed by a mandatory low gap. The block
// tracks tube inventory from customer deposits and reports completion,
// flagging shortage when the tubes cannot cover the request.
//
// Optional feature macro: VM_CHANGE_PRECHECK_EN
//   When defined, an extra CHECK cycle after accept decides up front whether
//   the current inventory can pay the whole request. If it cannot, nothing is
//   ejected and the request completes immediately with short=1.
//   When undefined, payout is greedy and partial: pay what the tubes allow,
//   then finish with short=1 if anything is still owed.
//
// Parameters:
//   PULSE_CYC  eject pulse width in cycles (>=1)
//   GAP_CYC    low time after each pulse in cycles (>=1)
//   TUBE_MAX   tube capacity in coins (<=31)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   req_valid   change request present
//   req_units   change owed, in Rs.5 units
//   req_ready   high only when idle (request is accepted on that edge)
//   dep_5       1-cycle pulse: coin routed into the Rs.5 tube
//   dep_10      1-cycle pulse: coin routed into the Rs.10 tube
//   eject_5     Rs.5 solenoid drive
//   eject_10    Rs.10 solenoid drive
//   busy        high whenever not idle
//   done        1-cycle completion pulse
//   short       valid with done: request not fully paid
//   paid_units  units paid for the current/last request
//   cnt_5       Rs.5 tube inventory
//   cnt_10      Rs.10 tube inventory
// ---------------------------------------------------------------------------
module vm_change_dispenser #(
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 2,
    parameter int TUBE_MAX  = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [7:0] req_units,
    output logic       req_ready,
    input  logic       dep_5,
    input  logic       dep_10,
    output logic       eject_5,
    output logic       eject_10,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [7:0] paid_units,
    output logic [4:0] cnt_5,
    output logic [4:0] cnt_10
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SEL,
        PULSE,
        GAP,
        DONE
    } state_t;

    // Timers load "width - 1" and count down to zero.
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);
    localparam logic [4:0] TUBE_FULL  = 5'(TUBE_MAX);

    state_t     state;
    logic [7:0] rem;
    logic [7:0] timer;

    logic       pick_10;
    logic       pick_5;
    logic [7:0] pick_units;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Coin selection for the current SEL cycle: prefer Rs.10 whenever at
    // least two units are owed, otherwise fall back to Rs.5.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick_10    = 1'b0;
        pick_5     = 1'b0;
        pick_units = 8'd0;
        if (state == SEL) begin
            if (rem >= 8'd2 && cnt_10 != 5'd0) begin
                pick_10    = 1'b1;
                pick_units = 8'd2;
            end else if (rem != 8'd0 && cnt_5 != 5'd0) begin
                pick_5     = 1'b1;
                pick_units = 8'd1;
            end
        end
    end

    // Tube update: a deposit and a same-cycle eject cancel out; a lone
    // deposit into a full tube is dropped.
    function automatic logic [4:0] tube_next(input logic [4:0] cnt,
                                             input logic       dep,
                                             input logic       dec);
        logic [4:0] nxt;
        nxt = cnt;
        if (dec && !dep) begin
            nxt = cnt - 5'd1;
        end else if (!dec && dep && cnt < TUBE_FULL) begin
            nxt = cnt + 5'd1;
        end
        return nxt;
    endfunction

`ifdef VM_CHANGE_PRECHECK_EN
    // Best-case payout: use as many Rs.10 coins as fit, then the remainder
    // must be covered by Rs.5 coins.
    logic [7:0] half_rem;
    logic [7:0] tens_used;
    logic [7:0] need_5;
    logic       payable;

    always_comb begin
        half_rem  = rem >> 1;
        tens_used = ({3'b000, cnt_10} < half_rem) ? {3'b000, cnt_10} : half_rem;
        need_5    = rem - (tens_used << 1);
        payable   = (need_5 <= {3'b000, cnt_5});
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rem        <= 8'd0;
            timer      <= 8'd0;
            paid_units <= 8'd0;
            cnt_5      <= 5'd0;
            cnt_10     <= 5'd0;
            eject_5    <= 1'b0;
            eject_10   <= 1'b0;
            done       <= 1'b0;
            short      <= 1'b0;
        end else begin
            // Deposits are counted in every state.
            cnt_5  <= tube_next(cnt_5, dep_5, pick_5);
            cnt_10 <= tube_next(cnt_10, dep_10, pick_10);
            done   <= 1'b0;
            short  <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rem        <= req_units;
                        paid_units <= 8'd0;
`ifdef VM_CHANGE_PRECHECK_EN
                        state      <= CHECK;
`else
                        state      <= SEL;
`endif
                    end
                end

`ifdef VM_CHANGE_PRECHECK_EN
                CHECK: begin
                    if (payable) begin
                        state <= SEL;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        short <= (rem != 8'd0);
                    end
                end
`endif

                SEL: begin
                    if (pick_10 || pick_5) begin
                        state      <= PULSE;
                        timer      <= PULSE_LAST;
                        eject_10   <= pick_10;
                        eject_5    <= pick_5;
                        rem        <= rem - pick_units;
                        paid_units <= paid_units + pick_units;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        short <= (rem != 8'd0);
                    end
                end

                PULSE: begin
                    if (timer == 8'd0) begin
                        eject_10 <= 1'b0;
                        eject_5  <= 1'b0;
                        timer    <= GAP_LAST;
                        state    <= GAP;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end

                GAP: begin
                    if (timer == 8'd0) begin
                        state <= SEL;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_vm_change_dispenser
//
// Directed bench for vm_change_dispenser. A schedule-level model (what coin
// is paid when, from inventory arithmetic and cycle offsets since accept)
// is compared against every DUT output on every falling edge, and each
// directed scenario pins its key cycle numbers and values with literals.
// ---------------------------------------------------------------------------
module tb_vm_change_dispenser;

    localparam int PULSE = 4;
    localparam int GAP   = 2;
    localparam int COIN  = 1 + PULSE + GAP;
`ifdef VM_CHANGE_PRECHECK_EN
    localparam bit PRE     = 1'b1;
    localparam int PRE_OFF = 1;
`else
    localparam bit PRE     = 1'b0;
    localparam int PRE_OFF = 0;
`endif

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [7:0] req_units;
    logic       req_ready;
    logic       dep_5;
    logic       dep_10;
    logic       eject_5;
    logic       eject_10;
    logic       busy;
    logic       done;
    logic       short;
    logic [7:0] paid_units;
    logic [4:0] cnt_5;
    logic [4:0] cnt_10;

    vm_change_dispenser #(
        .PULSE_CYC(PULSE),
        .GAP_CYC  (GAP),
        .TUBE_MAX (31)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_units (req_units),
        .req_ready (req_ready),
        .dep_5     (dep_5),
        .dep_10    (dep_10),
        .eject_5   (eject_5),
        .eject_10  (eject_10),
        .busy      (busy),
        .done      (done),
        .short     (short),
        .paid_units(paid_units),
        .cnt_5     (cnt_5),
        .cnt_10    (cnt_10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input integer act, input integer exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Model: a request is a timeline indexed by cycles since the accept edge.
    // At each decision cycle the next coin is chosen from model inventory;
    // its pulse window and the next decision cycle follow from fixed offsets.
    // -----------------------------------------------------------------------
    bit m_active;
    bit m_is10;
    int m_cyc, m_rem, m_paid, m_c5, m_c10;
    int m_next_sel, m_done_at, m_ps, m_pe;
    bit chk_en = 1'b0;

    function automatic int tube_upd(input int c, input bit dep, input bit dec);
        if (dec) return dep ? c : c - 1;
        if (dep && c < 31) return c + 1;
        return c;
    endfunction

    task automatic model_step();
        bit dec5, dec10;
        int t;
        dec5  = 1'b0;
        dec10 = 1'b0;
        if (rst) begin
            m_active = 1'b0; m_rem = 0; m_paid = 0; m_c5 = 0; m_c10 = 0;
            m_cyc = 0; m_done_at = -1; m_ps = 1; m_pe = 0; m_next_sel = -1;
        end else begin
            if (m_active) begin
                if (m_cyc == m_done_at) begin
                    m_active = 1'b0;
                end else if (PRE && m_cyc == 1) begin
                    t = (m_c10 < m_rem / 2) ? m_c10 : m_rem / 2;
                    if (m_rem - 2 * t <= m_c5) m_next_sel = 2;
                    else m_done_at = 2;
                end else if (m_cyc == m_next_sel) begin
                    if (m_rem >= 2 && m_c10 > 0) begin
                        m_is10 = 1'b1; dec10 = 1'b1; m_rem -= 2; m_paid += 2;
                        m_ps = m_cyc + 1; m_pe = m_cyc + PULSE; m_next_sel = m_cyc + COIN;
                    end else if (m_rem >= 1 && m_c5 > 0) begin
                        m_is10 = 1'b0; dec5 = 1'b1; m_rem -= 1; m_paid += 1;
                        m_ps = m_cyc + 1; m_pe = m_cyc + PULSE; m_next_sel = m_cyc + COIN;
                    end else begin
                        m_done_at = m_cyc + 1;
                    end
                end
                m_cyc++;
            end else if (req_valid) begin
                m_active = 1'b1; m_rem = int'(req_units); m_paid = 0; m_cyc = 1;
                m_next_sel = PRE ? 2 : 1; m_done_at = -1; m_ps = 1; m_pe = 0;
            end
            m_c10 = tube_upd(m_c10, dep_10, dec10);
            m_c5  = tube_upd(m_c5, dep_5, dec5);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    bit e_done, e_win;
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                e_done = m_active && (m_cyc == m_done_at);
                e_win  = m_active && (m_cyc >= m_ps) && (m_cyc <= m_pe);
                check("busy", busy, m_active);
                check("req_ready", req_ready, !m_active);
                check("eject_10", eject_10, e_win && m_is10);
                check("eject_5", eject_5, e_win && !m_is10);
                check("eject_exclusive", eject_5 & eject_10, 0);
                check("done", done, e_done);
                if (e_done) check("short", short, m_rem != 0);
                check("paid_units", paid_units, m_paid);
                check("cnt_5", cnt_5, m_c5);
                check("cnt_10", cnt_10, m_c10);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic deposit(input bit ten, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (ten) dep_10 = 1'b1; else dep_5 = 1'b1;
            @(posedge clk); #1;
            dep_10 = 1'b0;
            dep_5  = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Issue one request and follow it to done. Returns cycle numbers relative
    // to the accept edge (-1 when not seen). dep_sel drops a Rs.10 deposit
    // into the first coin-selection cycle.
    task automatic do_req(input logic [7:0] u, input bit dep_sel,
                          output integer dc, output integer f10, output integer f5,
                          output integer sh, output integer pd, output integer c10p);
        int n;
        dc = -1; f10 = -1; f5 = -1; sh = -1; pd = -1; c10p = -1;
        req_valid = 1'b1;
        req_units = u;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        dep_10 = dep_sel && (PRE_OFF == 0);
        for (int k = 1; k < 200; k++) begin
            @(negedge clk);
            if (eject_10 === 1'b1 && f10 < 0) begin
                f10  = k;
                c10p = cnt_10;
            end
            if (eject_5 === 1'b1 && f5 < 0) f5 = k;
            if (done === 1'b1) begin
                dc = k;
                sh = short;
                pd = paid_units;
                break;
            end
            @(posedge clk); #1;
            dep_10 = dep_sel && (k + 1 == 1 + PRE_OFF);
        end
        dep_10 = 1'b0;
    endtask

    integer dc, f10, f5, sh, pd, c10p;
    integer d1, d2;
    int     n;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_units = 8'd0; dep_5 = 1'b0; dep_10 = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_cnt_10", cnt_10, 0);
        check("rst_cnt_5", cnt_5, 0);
        check("rst_paid", paid_units, 0);

        // 3 units from 3 x Rs.10 and 2 x Rs.5: one Rs.10 then one Rs.5
        deposit(1'b1, 3);
        deposit(1'b0, 2);
        do_req(8'd3, 1'b0, dc, f10, f5, sh, pd, c10p);
        check("s1_first_eject_10", f10, 2 + PRE_OFF);
        check("s1_first_eject_5", f5, 9 + PRE_OFF);
        check("s1_done_cycle", dc, 16 + PRE_OFF);
        check("s1_short", sh, 0);
        check("s1_paid", pd, 3);
        check("s1_cnt_10", cnt_10, 2);
        check("s1_cnt_5", cnt_5, 1);

        // 2 units with only one Rs.5 in stock
        do_reset();
        deposit(1'b0, 1);
        do_req(8'd2, 1'b0, dc, f10, f5, sh, pd, c10p);
        check("s2_short", sh, 1);
`ifdef VM_CHANGE_PRECHECK_EN
        check("s2_done_cycle", dc, 2);
        check("s2_eject_5", f5, -1);
        check("s2_paid", pd, 0);
        check("s2_cnt_5", cnt_5, 1);
`else
        check("s2_done_cycle", dc, 9);
        check("s2_eject_5", f5, 2);
        check("s2_paid", pd, 1);
        check("s2_cnt_5", cnt_5, 0);
`endif

        // 1 unit with only a Rs.10 in stock: cannot pay
        do_reset();
        deposit(1'b1, 1);
        do_req(8'd1, 1'b0, dc, f10, f5, sh, pd, c10p);
        check("s3_done_cycle", dc, 2);
        check("s3_eject_10", f10, -1);
        check("s3_short", sh, 1);
        check("s3_paid", pd, 0);
        check("s3_cnt_10", cnt_10, 1);

        // Saturation, then deposit on the pick cycle nets to zero
        do_reset();
        deposit(1'b1, 32);
        check("s4_saturate", cnt_10, 31);
        do_req(8'd2, 1'b1, dc, f10, f5, sh, pd, c10p);
        check("s4_cnt_at_pulse", c10p, 31);
        check("s4_done_cycle", dc, 9 + PRE_OFF);
        check("s4_paid", pd, 2);
        check("s4_short", sh, 0);

        // Reset during the first Rs.10 pulse
        do_reset();
        deposit(1'b1, 2);
        req_valid = 1'b1;
        req_units = 8'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (eject_10 !== 1'b1 && n < 20);
        check("s5_pulse_seen", eject_10, 1);
        rst = 1'b1;
        @(negedge clk);
        check("s5_eject_10", eject_10, 0);
        check("s5_busy", busy, 0);
        check("s5_req_ready", req_ready, 1);
        check("s5_cnt_10", cnt_10, 0);
        check("s5_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Zero-unit request, with a second request held through busy
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_units = 8'd0;
        @(posedge clk); #1;
        d1 = -1;
        d2 = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
            end
            @(posedge clk); #1;
            if (k == 3 + PRE_OFF) req_valid = 1'b0;
        end
        check("s6_first_done", d1, 2 + PRE_OFF);
        check("s6_second_done", d2, 5 + 2 * PRE_OFF);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
